// File: rtl/axi_stream_pattern_tx.sv
// axi_stream_pattern_tx
// Valid/ready stream traffic source. A start pulse launches a burst of `length` beats
// carrying seed, seed+1, ... with m_axi_last on the final beat. Backpressure is honoured,
// and an optional idle gap can be inserted after each accepted non-last beat.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   start                one-cycle burst request (ignored while busy)
//   length, seed, gap    burst parameters, sampled on an accepted start
//   busy, done           burst in progress / one-cycle completion pulse
//   beat_count           beats accepted in the current or last burst
//   m_axi_valid/ready/data/last   master side of the stream
module axi_stream_pattern_tx #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LENGTH_WIDTH = 16,
  parameter int unsigned GAP_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LENGTH_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0]   seed,
  input  logic [GAP_WIDTH-1:0]    gap,
  output logic                    busy,
  output logic                    done,
  output logic [LENGTH_WIDTH-1:0] beat_count,
  output logic                    m_axi_valid,
  input  logic                    m_axi_ready,
  output logic [DATA_WIDTH-1:0]   m_axi_data,
  output logic                    m_axi_last
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [LENGTH_WIDTH-1:0] LenOne = LENGTH_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]    GapOne = GAP_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]   DatOne = DATA_WIDTH'(1);

  logic [1:0]              state_q, state_d;
  logic [LENGTH_WIDTH-1:0] len_q, len_d;
  logic [LENGTH_WIDTH-1:0] index_q, index_d;
  logic [LENGTH_WIDTH-1:0] beat_count_q, beat_count_d;
  logic [GAP_WIDTH-1:0]    gap_q, gap_d;
  logic [GAP_WIDTH-1:0]    gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    index_d      = index_q;
    beat_count_d = beat_count_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    data_d       = data_q;
    valid_d      = valid_q;
    last_d       = last_q;
    busy_d       = busy_q;
    done_d       = done_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          len_d        = length;
          gap_d        = gap;
          index_d      = '0;
          beat_count_d = '0;
          busy_d       = 1'b1;
          if (length != '0) begin
            state_d = StSend;
            valid_d = 1'b1;
            data_d  = seed;
            last_d  = (length == LenOne);
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StSend: begin
        // valid_q is always high in this state, so ready alone marks the handshake
        if (m_axi_ready) begin
          index_d      = index_q + LenOne;
          beat_count_d = beat_count_q + LenOne;
          if (last_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else if (gap_q == '0) begin
            data_d = data_q + DatOne;
            last_d = ((index_q + LenOne) == (len_q - LenOne));
          end else begin
            // data/last stay at the accepted beat while valid is low
            valid_d   = 1'b0;
            gap_cnt_d = gap_q;
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapOne) begin
          // index_q already points at the next beat
          valid_d = 1'b1;
          data_d  = data_q + DatOne;
          last_d  = (index_q == (len_q - LenOne));
          state_d = StSend;
        end else begin
          gap_cnt_d = gap_cnt_q - GapOne;
        end
      end
      default: begin  // StDone
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      index_q      <= '0;
      beat_count_q <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      index_q      <= index_d;
      beat_count_q <= beat_count_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign beat_count  = beat_count_q;
  assign m_axi_valid = valid_q;
  assign m_axi_data  = data_q;
  assign m_axi_last  = last_q;

endmodule

// File: tb/tb_axi_stream_pattern_tx.sv
// Directed self-checking bench for axi_stream_pattern_tx. Inputs are driven and outputs
// sampled on the falling edge; "cycle 0" is the cycle in which start is held high.
module tb_axi_stream_pattern_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] length;
  logic [31:0] seed;
  logic [3:0]  gap;
  logic        busy;
  logic        done;
  logic [15:0] beat_count;
  logic        m_axi_valid;
  logic        m_axi_ready;
  logic [31:0] m_axi_data;
  logic        m_axi_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_stream_pattern_tx #(
    .DATA_WIDTH  (32),
    .LENGTH_WIDTH(16),
    .GAP_WIDTH   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .length     (length),
    .seed       (seed),
    .gap        (gap),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count),
    .m_axi_valid(m_axi_valid),
    .m_axi_ready(m_axi_ready),
    .m_axi_data (m_axi_data),
    .m_axi_last (m_axi_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue start during the current cycle (cycle 0); returns at the cycle-1 sample point.
  task automatic launch(input logic [15:0] l, input logic [31:0] s, input logic [3:0] g);
    start  = 1'b1;
    length = l;
    seed   = s;
    gap    = g;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic        rdy_pat [16] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1};
  logic        vpat    [8]  = '{1, 0, 0, 1, 0, 0, 1, 0};
  logic [31:0] wrap_exp [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};

  int          acc;
  int          beats;
  logic        seen_done;
  logic        pend;
  logic [31:0] pend_data;

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    length      = '0;
    seed        = '0;
    gap         = '0;
    m_axi_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", m_axi_valid, 0);
    check("rst_last",  m_axi_last,  0);
    check("rst_data",  m_axi_data,  0);
    check("rst_busy",  busy,        0);
    check("rst_done",  done,        0);
    check("rst_count", beat_count,  0);
    reset = 1'b0;
    @(negedge clk);

    // Burst 1: four beats back to back from 0x10
    m_axi_ready = 1'b1;
    launch(16'd4, 32'h10, 4'd0);
    for (int i = 1; i <= 4; i++) begin
      check("b1_valid", m_axi_valid, 1);
      check("b1_busy",  busy, 1);
      check("b1_data",  m_axi_data, 32'h10 + i - 1);
      check("b1_last",  m_axi_last, (i == 4));
      @(negedge clk);
    end
    check("b1_done_valid", m_axi_valid, 0);
    check("b1_done",       done, 1);
    check("b1_count",      beat_count, 4);
    @(negedge clk);
    check("b1_idle_busy", busy, 0);
    check("b1_idle_done", done, 0);

    // Burst 2: three beats under a fixed irregular ready pattern
    m_axi_ready = 1'b0;
    launch(16'd3, 32'h0, 4'd0);
    acc       = 0;
    seen_done = 1'b0;
    pend      = 1'b0;
    pend_data = '0;
    for (int c = 0; c < 30 && !seen_done; c++) begin
      if (pend) begin
        check("b2_stall_valid", m_axi_valid, 1);
        check("b2_stall_data",  m_axi_data, pend_data);
      end
      if (m_axi_valid) begin
        check("b2_data", m_axi_data, acc);
        check("b2_last", m_axi_last, (acc == 2));
      end
      if (done) seen_done = 1'b1;
      m_axi_ready = rdy_pat[c % 16];
      pend        = m_axi_valid && !m_axi_ready;
      pend_data   = m_axi_data;
      if (m_axi_valid && m_axi_ready) acc++;
      @(negedge clk);
    end
    check("b2_seen_done", seen_done, 1);
    check("b2_accepted",  acc, 3);
    check("b2_count",     beat_count, 3);

    // Burst 3: gap of two idle cycles between beats
    m_axi_ready = 1'b1;
    @(negedge clk);
    launch(16'd3, 32'h0, 4'd2);
    for (int c = 1; c <= 8; c++) begin
      check("b3_valid", m_axi_valid, vpat[c-1]);
      check("b3_done",  done, (c == 8));
      if (m_axi_valid) check("b3_data", m_axi_data, (c - 1) / 3);
      @(negedge clk);
    end
    check("b3_count", beat_count, 3);

    // Zero-length burst
    @(negedge clk);
    launch(16'd0, 32'h55, 4'd0);
    check("z_valid", m_axi_valid, 0);
    check("z_done",  done, 1);
    check("z_busy",  busy, 1);
    @(negedge clk);
    check("z_idle_busy",  busy, 0);
    check("z_idle_valid", m_axi_valid, 0);
    check("z_count",      beat_count, 0);

    // Start while busy must be ignored
    launch(16'd5, 32'h100, 4'd0);
    beats = 0;
    start  = 1'b1;
    length = 16'd2;
    seed   = 32'h999;
    for (int c = 1; c <= 8; c++) begin
      if (m_axi_valid) begin
        check("i_data", m_axi_data, 32'h100 + beats);
        beats++;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check("i_beats", beats, 5);
    check("i_count", beat_count, 5);

    // Data wraps modulo 2^32
    @(negedge clk);
    launch(16'd3, 32'hFFFF_FFFE, 4'd0);
    for (int i = 0; i < 3; i++) begin
      check("w_data", m_axi_data, wrap_exp[i]);
      @(negedge clk);
    end
    check("w_done", done, 1);

    // Reset mid-burst while stalled
    @(negedge clk);
    m_axi_ready = 1'b0;
    launch(16'd4, 32'h50, 4'd0);
    check("r_valid_pre", m_axi_valid, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("r_valid", m_axi_valid, 0);
    check("r_last",  m_axi_last, 0);
    check("r_data",  m_axi_data, 0);
    check("r_busy",  busy, 0);
    check("r_done",  done, 0);
    check("r_count", beat_count, 0);
    @(negedge clk);
    check("r_no_done", done, 0);
    m_axi_ready = 1'b1;
    launch(16'd2, 32'h7, 4'd0);
    check("r2_data0", m_axi_data, 32'h7);
    check("r2_cnt0",  beat_count, 0);
    @(negedge clk);
    check("r2_data1", m_axi_data, 32'h8);
    check("r2_last1", m_axi_last, 1);
    @(negedge clk);
    check("r2_done",  done, 1);
    check("r2_count", beat_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
